// File: rtl/axi_4k_rd_master_if.sv
// axi_4k_rd_master_if: AXI4 read-address and read-data channels between a read master and its slave.
interface axi_4k_rd_master_if #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128
);
    logic [C_M_AXI_ID_WIDTH-1:0]   arid;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arlock;
    logic [3:0]                    arcache;
    logic [2:0]                    arprot;
    logic [3:0]                    arqos;
    logic                          aruser;
    logic                          arvalid;
    logic                          arready;
    logic [C_M_AXI_ID_WIDTH-1:0]   rid;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_4k_rd_master.sv
// axi_4k_rd_master: splits one linear read command into INCR bursts that never cross 4 KB.
// Define AXI_RD_PIPE_EN to let up to two bursts be outstanding at once.
module axi_4k_rd_master #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_MAX_BURST_LEN    = 16,
    parameter int C_LEN_WIDTH        = 16
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_LEN_WIDTH-1:0]        cmd_beats,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          rd_last,
    output logic                          done,
    output logic                          err,
    axi_4k_rd_master_if.master            m_axi
);
    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t                        state, state_nx;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [C_LEN_WIDTH-1:0]        remaining;
    logic [12:0]                   room, cap, beats;
    logic                          ar_hs, r_hs, last_hs, rem_zero, r_active, ar_want;
    logic                          unused_ok;
`ifdef AXI_RD_PIPE_EN
    logic [1:0]                    outstanding, outstanding_nx;
`endif

    // Burst length is the smallest of what is left, the burst cap and the room before the next 4 KB page.
    assign room     = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
    assign cap      = (32'(remaining) > C_MAX_BURST_LEN) ? 13'(C_MAX_BURST_LEN) : 13'(remaining);
    assign beats    = (cap < room) ? cap : room;
    assign rem_zero = remaining == '0;
    assign ar_hs    = m_axi.arvalid && m_axi.arready;
    assign r_hs     = r_active && m_axi.rvalid && rd_ready;
    assign last_hs  = r_hs && m_axi.rlast;
    assign unused_ok = ^{m_axi.rid, m_axi.rresp[0]};

`ifdef AXI_RD_PIPE_EN
    assign outstanding_nx = outstanding + 2'(ar_hs) - 2'(last_hs);
    assign r_active       = outstanding != 2'd0;
    assign ar_want        = state == AR && !rem_zero && outstanding != 2'd2;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
        if (!M_AXI_ARESETN) outstanding <= 2'd0;
        else outstanding <= outstanding_nx;
`else
    assign r_active = state == R;
    assign ar_want  = state == AR;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
        if (!M_AXI_ARESETN) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid) state_nx = (cmd_beats == '0) ? DONE : AR;
`ifdef AXI_RD_PIPE_EN
            AR:      if (rem_zero && outstanding_nx == 2'd0) state_nx = DONE;
`else
            AR:      if (ar_hs) state_nx = R;
            R:       if (last_hs) state_nx = rem_zero ? DONE : AR;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = state;
        endcase
    end

    always_comb begin
        cmd_ready     = state == IDLE;
        done          = state == DONE;
        rd_valid      = r_active && m_axi.rvalid;
        rd_data       = m_axi.rdata;
        m_axi.rready  = r_active && rd_ready;
        m_axi.arvalid = ar_want;
        m_axi.araddr  = addr;
        m_axi.arlen   = (beats == 13'd0) ? 8'd0 : 8'(beats - 13'd1);
        m_axi.arsize  = 3'(SZ);
        m_axi.arburst = 2'b01;
        m_axi.arcache = 4'b0011;
        m_axi.arid    = '0;
        m_axi.arlock  = 1'b0;
        m_axi.arprot  = 3'b000;
        m_axi.arqos   = 4'b0000;
        m_axi.aruser  = 1'b0;
`ifdef AXI_RD_PIPE_EN
        rd_last       = r_active && m_axi.rlast && rem_zero && outstanding == 2'd1;
`else
        rd_last       = r_active && m_axi.rlast && rem_zero;
`endif
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
        if (!M_AXI_ARESETN) begin
            addr      <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                addr      <= cmd_addr & ~C_M_AXI_ADDR_WIDTH'(BYTES - 1);
                remaining <= cmd_beats;
                err       <= 1'b0;
            end
            if (ar_hs) begin
                addr      <= addr + (C_M_AXI_ADDR_WIDTH'(beats) << SZ);
                remaining <= remaining - C_LEN_WIDTH'(beats);
            end
            if (r_hs && m_axi.rresp[1]) err <= 1'b1;
        end
endmodule
